// File: rtl/divseq_pkg.sv
// Shared definitions for the HI/LO divide sequencer: FSM states, default
// timing parameters and the width of the WAIT-state guard/timeout counter.
package divseq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      COMMIT = 2'd3
   } divseq_state_e;

   localparam int DEF_TIMEOUT_CYC = 64;
   localparam int DEF_GUARD_CYC   = 2;

   // The counter must be able to hold TIMEOUT_CYC itself.
   function automatic int divseqCntWidth(input int timeoutCyc);
      return (timeoutCyc < 1) ? 1 : $clog2(timeoutCyc + 1);
   endfunction

   localparam int DEF_CNT_W = divseqCntWidth(DEF_TIMEOUT_CYC);

endpackage

// File: rtl/divseq_hilo.sv
// Architectural HI/LO register pair. Two writers: the MTHI/MTLO port and the
// division commit port. The commit port wins if both fire on one edge, although
// the sequencer never lets that happen.
module divseq_hilo
   import divseq_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mthiEn_i,
   input  logic        mtloEn_i,
   input  logic [31:0] mtWdata_i,
   input  logic        commitEn_i,
   input  logic [31:0] commitHi_i,
   input  logic [31:0] commitLo_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   logic [31:0] hi_q;
   logic [31:0] lo_q;

   // HI/LO update: commit overwrites both halves, MT writes touch one half each
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (commitEn_i) begin
         hi_q <= commitHi_i;
         lo_q <= commitLo_i;
      end else begin
         if (mthiEn_i) begin
            hi_q <= mtWdata_i;
         end
         if (mtloEn_i) begin
            lo_q <= mtWdata_i;
         end
      end
   end

   // A commit and an MT write on the same edge would mean the stall logic leaked
   CommitMtExclusive: assert property (@(posedge clk) disable iff (!rst_n)
      !(commitEn_i && (mthiEn_i || mtloEn_i)));

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: rtl/div_sequencer.sv
// Divide sequencer for the MIPS core: accepts DIV/DIVU, drives the multi-cycle
// divider, commits quotient to LO and remainder to HI, and stalls HI/LO
// accesses while a division is in flight.
// Optional build macro DIVSEQ_ZERO_BYPASS_EN: divide-by-zero skips the divider
// and commits lo = 32'hFFFF_FFFF, hi = dividend two edges after issue.
module div_sequencer
   import divseq_pkg::*;
#(
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int GUARD_CYC   = DEF_GUARD_CYC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        issue_valid,
   input  logic        issue_signed,
   input  logic [31:0] issue_a,
   input  logic [31:0] issue_b,
   output logic        issue_ready,
   input  logic        flush,
   input  logic        rd_hi,
   input  logic        rd_lo,
   input  logic        mthi_en,
   input  logic        mtlo_en,
   input  logic [31:0] mt_wdata,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        hilo_stall,
   output logic        div_err,
   output logic [31:0] div_a,
   output logic [31:0] div_b,
   output logic        div_sign,
   output logic        div_start,
   input  logic        div_done,
   input  logic [31:0] div_q,
   input  logic [31:0] div_r
);

   localparam int CntW = divseqCntWidth(TIMEOUT_CYC);
   localparam logic [CntW-1:0] GuardVal    = CntW'(GUARD_CYC);
   localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYC - 1);

   divseq_state_e     state_q;
   logic [CntW-1:0]   cnt_q;
   logic [31:0]       divA_q;
   logic [31:0]       divB_q;
   logic              divSign_q;
   logic              divStart_q;
   logic              divErr_q;
`ifdef DIVSEQ_ZERO_BYPASS_EN
   logic              bypass_q;
`endif

   logic              commitEn;
   logic [31:0]       commitHi;
   logic [31:0]       commitLo;
   logic              mthiGated;
   logic              mtloGated;

   // Sequencer FSM: operand latch, start pulse, guarded wait with timeout, commit
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         divA_q     <= '0;
         divB_q     <= '0;
         divSign_q  <= 1'b0;
         divStart_q <= 1'b0;
         divErr_q   <= 1'b0;
`ifdef DIVSEQ_ZERO_BYPASS_EN
         bypass_q   <= 1'b0;
`endif
      end else begin
         divStart_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (issue_valid) begin
                  divA_q    <= issue_a;
                  divB_q    <= issue_b;
                  divSign_q <= issue_signed;
`ifdef DIVSEQ_ZERO_BYPASS_EN
                  if (issue_b == '0) begin
                     bypass_q <= 1'b1;
                     state_q  <= COMMIT;
                  end else begin
                     bypass_q   <= 1'b0;
                     divStart_q <= 1'b1;
                     state_q    <= LAUNCH;
                  end
`else
                  divStart_q <= 1'b1;
                  state_q    <= LAUNCH;
`endif
               end
            end
            LAUNCH: begin
               cnt_q   <= '0;
               state_q <= flush ? IDLE : WAIT;
            end
            WAIT: begin
               cnt_q <= cnt_q + 1'b1;
               if (flush) begin
                  state_q <= IDLE;
               end else if ((cnt_q >= GuardVal) && div_done) begin
                  state_q <= COMMIT;
               end else if (cnt_q == TimeoutLast) begin
                  divErr_q <= 1'b1;
                  state_q  <= IDLE;
               end
            end
            COMMIT: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Commit data selection: divider results normally, fixed pattern on bypass
   always_comb begin
      commitEn = (state_q == COMMIT);
      commitHi = div_r;
      commitLo = div_q;
`ifdef DIVSEQ_ZERO_BYPASS_EN
      if (bypass_q) begin
         commitHi = divA_q;
         commitLo = 32'hFFFF_FFFF;
      end
`endif
   end

   // MT writes only land while idle; otherwise the stall keeps them in decode
   always_comb begin
      mthiGated = mthi_en && (state_q == IDLE);
      mtloGated = mtlo_en && (state_q == IDLE);
   end

   divseq_hilo uHilo (
      .clk        (clk),
      .rst_n      (rst_n),
      .mthiEn_i   (mthiGated),
      .mtloEn_i   (mtloGated),
      .mtWdata_i  (mt_wdata),
      .commitEn_i (commitEn),
      .commitHi_i (commitHi),
      .commitLo_i (commitLo),
      .hi_o       (hi),
      .lo_o       (lo)
   );

   assign busy        = (state_q != IDLE);
   assign issue_ready = (state_q == IDLE);
   assign hilo_stall  = busy && (rd_hi || rd_lo || mthi_en || mtlo_en || issue_valid);
   assign div_err     = divErr_q;
   assign div_a       = divA_q;
   assign div_b       = divB_q;
   assign div_sign    = divSign_q;
   assign div_start   = divStart_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer with a behavioural divider model.
module tb_div_sequencer;

   localparam int TIMEOUT = 64;
   localparam int GUARD   = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        issue_valid = 1'b0;
   logic        issue_signed = 1'b0;
   logic [31:0] issue_a = '0;
   logic [31:0] issue_b = '0;
   logic        issue_ready;
   logic        flush = 1'b0;
   logic        rd_hi = 1'b0;
   logic        rd_lo = 1'b0;
   logic        mthi_en = 1'b0;
   logic        mtlo_en = 1'b0;
   logic [31:0] mt_wdata = '0;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        hilo_stall;
   logic        div_err;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic        div_sign;
   logic        div_start;
   logic        div_done = 1'b0;
   logic [31:0] div_q = '0;
   logic [31:0] div_r = '0;

   int assertCount = 0;
   int failCount = 0;

   // Divider model controls
   int  modelLatency = 4;
   int  modelStale = 0;
   bit  modelNever = 1'b0;
   int  remLeft = 0;
   int  staleLeft = 0;
   logic [31:0] pendQ;
   logic [31:0] pendR;

   div_sequencer #(.TIMEOUT_CYC(TIMEOUT), .GUARD_CYC(GUARD)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .issue_valid  (issue_valid),
      .issue_signed (issue_signed),
      .issue_a      (issue_a),
      .issue_b      (issue_b),
      .issue_ready  (issue_ready),
      .flush        (flush),
      .rd_hi        (rd_hi),
      .rd_lo        (rd_lo),
      .mthi_en      (mthi_en),
      .mtlo_en      (mtlo_en),
      .mt_wdata     (mt_wdata),
      .hi           (hi),
      .lo           (lo),
      .busy         (busy),
      .hilo_stall   (hilo_stall),
      .div_err      (div_err),
      .div_a        (div_a),
      .div_b        (div_b),
      .div_sign     (div_sign),
      .div_start    (div_start),
      .div_done     (div_done),
      .div_q        (div_q),
      .div_r        (div_r)
   );

   always #5 clk = ~clk;

   // Reference arithmetic: MIPS truncating division; divide-by-zero convention
   // of this divider model is q = all ones, r = dividend
   function automatic void refDivide(input logic s, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] q, output logic [31:0] r);
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (s) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // Divider model: restarts on div_start, optionally keeps a stale done high
   // for a few cycles, then raises done with fresh results after modelLatency
   always @(negedge clk) begin
      if (div_start === 1'b1) begin
         refDivide(div_sign, div_a, div_b, pendQ, pendR);
         remLeft = modelNever ? 0 : modelLatency;
         staleLeft = modelStale;
         if (staleLeft == 0) div_done = 1'b0;
      end else begin
         if (staleLeft > 0) begin
            staleLeft--;
            if (staleLeft == 0) div_done = 1'b0;
         end
         if (remLeft > 0) begin
            remLeft--;
            if (remLeft == 0) begin
               div_q = pendQ;
               div_r = pendR;
               div_done = 1'b1;
               staleLeft = 0;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
      end
   endtask

   // All drivers below assume they start #1 after a rising edge
   task automatic issueOnly(input logic s, input logic [31:0] a, input logic [31:0] b,
                            input bit mtHi, input logic [31:0] mtData);
      issue_valid = 1'b1;
      issue_signed = s;
      issue_a = a;
      issue_b = b;
      mthi_en = mtHi;
      mt_wdata = mtData;
      @(posedge clk); #1;
      issue_valid = 1'b0;
      mthi_en = 1'b0;
   endtask

   // Runs until busy drops; edges counts E0 through the result edge inclusive
   task automatic waitIdle(input logic s, input bit holdRd, input bit mtloBusy,
                           output int edges, output int starts, output bit signOk, output bit stallOk);
      edges = 1;
      starts = 0;
      signOk = 1'b1;
      stallOk = 1'b1;
      if (mtloBusy) begin
         mtlo_en = 1'b1;
         mt_wdata = 32'h0000_AAAA;
      end
      while (busy === 1'b1 && edges < 200) begin
         if (div_start === 1'b1) starts++;
         if (div_sign !== s) signOk = 1'b0;
         if (holdRd && hilo_stall !== 1'b1) stallOk = 1'b0;
         @(posedge clk); #1;
         edges++;
      end
      if (holdRd && hilo_stall !== 1'b0) stallOk = 1'b0;
      checkOutput("busy_released", {31'd0, busy}, 32'd0);
   endtask

   task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output int edges, output int starts, output bit signOk);
      bit stallOk;
      issueOnly(s, a, b, 1'b0, 32'd0);
      waitIdle(s, 1'b0, 1'b0, edges, starts, signOk, stallOk);
   endtask

   task automatic mtWrite(input bit toHi, input logic [31:0] data);
      mthi_en = toHi;
      mtlo_en = !toHi;
      mt_wdata = data;
      @(posedge clk); #1;
      mthi_en = 1'b0;
      mtlo_en = 1'b0;
   endtask

   typedef struct {
      logic        sign;
      logic [31:0] a;
      logic [31:0] b;
      int          latency;
      logic [31:0] expHi;
      logic [31:0] expLo;
   } vec_t;

   vec_t vecs[5];

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: actual=hung required=finished");
      $fatal(1, "[TB] simulation hung");
   end

   initial begin
      int edges, starts;
      bit signOk, stallOk;
      logic [31:0] expQ, expR, refHi, refLo, s0;

      vecs[0] = '{1'b0, 32'd100,        32'd7,        20, 32'd2,         32'd14};
      vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        6,  32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[2] = '{1'b0, 32'hFFFF_FFF9,  32'd2,        1,  32'h0000_0001, 32'h7FFF_FFFC};
      vecs[3] = '{1'b1, 32'd100,        32'hFFFF_FFF9, 3, 32'd2,         32'hFFFF_FFF2};
      vecs[4] = '{1'b1, 32'hFFFF_FF9C,  32'd7,        9,  32'hFFFF_FFFE, 32'hFFFF_FFF2};

      // Reset
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkOutput("reset_hi", hi, 32'd0);
      checkOutput("reset_lo", lo, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_err", {31'd0, div_err}, 32'd0);
      checkOutput("reset_start", {31'd0, div_start}, 32'd0);
      checkOutput("reset_ready", {31'd0, issue_ready}, 32'd1);
      checkOutput("reset_div_a", div_a, 32'd0);
      checkOutput("reset_div_b", div_b, 32'd0);
      checkOutput("reset_div_sign", {31'd0, div_sign}, 32'd0);

      // Table vectors, issued back-to-back
      for (int i = 0; i < 5; i++) begin
         modelLatency = vecs[i].latency;
         checkOutput($sformatf("vec%0d_ready", i), {31'd0, issue_ready}, 32'd1);
         applyStimulus(vecs[i].sign, vecs[i].a, vecs[i].b, edges, starts, signOk);
         checkOutput($sformatf("vec%0d_hi", i), hi, vecs[i].expHi);
         checkOutput($sformatf("vec%0d_lo", i), lo, vecs[i].expLo);
         checkOutput($sformatf("vec%0d_starts", i), starts, 32'd1);
         checkOutput($sformatf("vec%0d_sign", i), {31'd0, signOk}, 32'd1);
         if (vecs[i].latency == 1)
            checkOutput("min_latency", edges - 1, GUARD + 3);
      end

      // rd_hi held through a divide, MTLO presented only while busy
      modelLatency = 7;
      rd_hi = 1'b1;
      issueOnly(1'b0, 32'd1000, 32'd9, 1'b0, 32'd0);
      waitIdle(1'b0, 1'b1, 1'b1, edges, starts, signOk, stallOk);
      rd_hi = 1'b0;
      checkOutput("stall_tracks_busy", {31'd0, stallOk}, 32'd1);
      checkOutput("stall_commit_hi", hi, 32'd1);
      checkOutput("stall_commit_lo", lo, 32'd111);
      @(posedge clk); #1;
      mtlo_en = 1'b0;
      checkOutput("mtlo_after_idle", lo, 32'h0000_AAAA);
      checkOutput("mtlo_hi_kept", hi, 32'd1);

      // MTHI and issue in the same idle cycle: MT lands, commit later overwrites
      modelLatency = 4;
      issueOnly(1'b0, 32'd77, 32'd10, 1'b1, 32'h0000_5555);
      checkOutput("same_cycle_mthi", hi, 32'h0000_5555);
      waitIdle(1'b0, 1'b0, 1'b0, edges, starts, signOk, stallOk);
      checkOutput("same_cycle_commit_hi", hi, 32'd7);
      checkOutput("same_cycle_commit_lo", lo, 32'd7);

      // Flush in the 5th WAIT cycle
      mtWrite(1'b1, 32'h11);
      mtWrite(1'b0, 32'h22);
      checkOutput("preflush_hi", hi, 32'h11);
      checkOutput("preflush_lo", lo, 32'h22);
      modelLatency = 20;
      modelStale = 0;
      issueOnly(1'b0, 32'd1000, 32'd3, 1'b0, 32'd0);
      repeat (5) begin
         @(posedge clk); #1;
      end
      issue_valid = 1'b1;
      #1;
      checkOutput("stall_on_issue", {31'd0, hilo_stall}, 32'd1);
      checkOutput("not_ready_busy", {31'd0, issue_ready}, 32'd0);
      issue_valid = 1'b0;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checkOutput("flush_idle", {31'd0, busy}, 32'd0);
      checkOutput("flush_hi", hi, 32'h11);
      checkOutput("flush_lo", lo, 32'h22);
      checkOutput("flush_err", {31'd0, div_err}, 32'd0);
      repeat (25) begin
         @(posedge clk); #1;
      end
      checkOutput("flush_no_late_hi", hi, 32'h11);
      checkOutput("stale_done_present", {31'd0, div_done}, 32'd1);
      // Stale done (with stale results) lingers through the guard window
      modelStale = 3;
      modelLatency = 8;
      applyStimulus(1'b0, 32'd50, 32'd6, edges, starts, signOk);
      modelStale = 0;
      checkOutput("guard_hi", hi, 32'd2);
      checkOutput("guard_lo", lo, 32'd8);

      // Flush during COMMIT is ignored: latency 1 puts COMMIT in the cycle after E4
      modelLatency = 1;
      issueOnly(1'b0, 32'd99, 32'd4, 1'b0, 32'd0);
      repeat (4) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checkOutput("commit_flush_busy", {31'd0, busy}, 32'd0);
      checkOutput("commit_flush_hi", hi, 32'd3);
      checkOutput("commit_flush_lo", lo, 32'd24);

      // Timeout: divider never completes
      refHi = hi;
      refLo = lo;
      modelNever = 1'b1;
      applyStimulus(1'b1, 32'd500, 32'd5, edges, starts, signOk);
      modelNever = 1'b0;
      checkOutput("timeout_edges", edges - 1, TIMEOUT + 1);
      checkOutput("timeout_err", {31'd0, div_err}, 32'd1);
      checkOutput("timeout_hi", hi, refHi);
      checkOutput("timeout_lo", lo, refLo);
      mtWrite(1'b1, 32'h1);
      checkOutput("err_sticky", {31'd0, div_err}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checkOutput("rst_err", {31'd0, div_err}, 32'd0);
      checkOutput("rst_hi", hi, 32'd0);
      checkOutput("rst_lo", lo, 32'd0);
      checkOutput("rst_ready", {31'd0, issue_ready}, 32'd1);

      // Divide by zero
      modelLatency = 5;
      applyStimulus(1'b0, 32'h1234, 32'd0, edges, starts, signOk);
`ifdef DIVSEQ_ZERO_BYPASS_EN
      checkOutput("zero_starts", starts, 32'd0);
      checkOutput("zero_edges", edges - 1, 32'd1);
`else
      checkOutput("zero_starts", starts, 32'd1);
`endif
      checkOutput("zero_hi", hi, 32'h1234);
      checkOutput("zero_lo", lo, 32'hFFFF_FFFF);

      // Randomized divides and MT writes against the arithmetic model
      refHi = hi;
      refLo = lo;
      for (int k = 0; k < 20; k++) begin
         logic sgn;
         logic [31:0] a, b;
         if ($urandom_range(0, 1) == 1) begin
            bit toHi = ($urandom_range(0, 1) == 1);
            s0 = $urandom;
            mtWrite(toHi, s0);
            if (toHi) refHi = s0; else refLo = s0;
            checkOutput($sformatf("rnd%0d_mt_hi", k), hi, refHi);
            checkOutput($sformatf("rnd%0d_mt_lo", k), lo, refLo);
         end
         sgn = ($urandom_range(0, 1) == 1);
         a = $urandom;
         b = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 1000) : $urandom;
         if (b == 32'd0) b = 32'd3;
         if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd2;
         modelLatency = $urandom_range(1, 10);
         modelStale = $urandom_range(0, 1);
         refDivide(sgn, a, b, expQ, expR);
         applyStimulus(sgn, a, b, edges, starts, signOk);
         refHi = expR;
         refLo = expQ;
         checkOutput($sformatf("rnd%0d_hi", k), hi, refHi);
         checkOutput($sformatf("rnd%0d_lo", k), lo, refLo);
         checkOutput($sformatf("rnd%0d_sign", k), {31'd0, signOk}, 32'd1);
      end
      modelStale = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Controller that owns the multi-cycle divider and the HI/LO register pair in the MIPS core. It accepts DIV/DIVU issues from the decode stage and latches the operands. It pulses the divider's start/reset, waits for completion and commits quotient to LO and remainder to HI. It also stalls MFHI/MFLO/MTHI/MTLO while a division is in flight.

## Interface
Parameters:
- TIMEOUT_CYC, 64: max cycles in WAIT before abandoning the division and flagging error.
- GUARD_CYC, 2: cycles after start during which div_done is ignored (stale done from the previous operation).

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, synchronous, active-low
- issue_valid  in  1  DIV/DIVU issue request
- issue_signed  in  1  1 = DIV, 0 = DIVU
- issue_a, issue_b  in  32  dividend, divisor
- issue_ready  out  1  high only in IDLE; issue accepted when valid & ready at clk edge
- flush  in  1  pipeline flush; abandons in-flight division
- rd_hi, rd_lo  in  1  MFHI/MFLO in decode
- mthi_en, mtlo_en  in  1  MTHI/MTLO write enables
- mt_wdata  in  32  MTHI/MTLO data
- hi, lo  out  32  architectural HI/LO (registered)
- busy  out  1  state ≠ IDLE
- hilo_stall  out  1  busy & (rd_hi | rd_lo | mthi_en | mtlo_en | issue_valid)
- div_err  out  1  sticky timeout flag, cleared only by reset
- div_a, div_b  out  32  latched operands to divider
- div_sign  out  1  latched issue_signed
- div_start  out  1  one-cycle pulse to the divider's reset/start input
- div_done  in  1  divider completion (level, stays high until next start)
- div_q, div_r  in  32  divider quotient/remainder

## Operation
- States: IDLE, LAUNCH, WAIT, COMMIT.
- IDLE: on issue_valid, latch issue_a/b/signed into div_a/b/sign. Go to LAUNCH.
- IDLE, MT write with no issue: hi/lo ← mt_wdata at that edge.
- IDLE, MT write and issue in the same cycle: both take effect. The division commit later overwrites both hi and lo.
- LAUNCH: div_start = 1 for exactly this cycle. Clear guard/timeout counter. Go to WAIT.
- WAIT: counter increments every cycle.
  - div_done is ignored while counter < GUARD_CYC.
  - After that, div_done = 1 → COMMIT.
  - counter reaches TIMEOUT_CYC → set div_err, go to IDLE, hi/lo unchanged.
- COMMIT: lo ← div_q, hi ← div_r at the edge ending this cycle. Go to IDLE.
- Sign handling is the divider's job. The sequencer passes operands and results through unmodified.
- flush in LAUNCH or WAIT → IDLE next edge, no commit, div_err unaffected. flush in COMMIT is ignored (commit completes). flush in IDLE has no effect.
- MT writes and issues while busy are not applied. hilo_stall holds them in decode until IDLE.
- Reset (any state): state IDLE, hi = lo = 0, div_a = div_b = 0, div_sign = 0, div_start = 0, busy = 0, div_err = 0, counter = 0. issue_ready = 1 the cycle after reset deasserts.

## Timing
- Issue accepted at edge E0. LAUNCH during cycle 1 (div_start high). WAIT from cycle 2.
- div_done first sampled high at edge Ed → COMMIT the following cycle. hi/lo valid at edge Ed+1. busy low and issue_ready high from Ed+1.
- Minimum issue-to-result latency: GUARD_CYC + 3 edges.
- hilo_stall is combinational from rd_*/mt*/issue_valid and busy. It deasserts in the same cycle busy falls, so MFHI in that cycle reads the committed value.
- Back-to-back divides: second issue accepted at the first edge after COMMIT.

## Configuration
- DIVSEQ_ZERO_BYPASS_EN defined: an issue with issue_b == 0 goes IDLE → COMMIT directly. No div_start is issued. At the commit edge lo ← 32'hFFFF_FFFF and hi ← issue_a, regardless of sign. Total 2 edges.
- Not defined: divide-by-zero runs through the divider like any other operand. Result is whatever the divider produces. Timeout rules apply.

## Structure
- Package divseq_pkg holds:
  - state enum (IDLE, LAUNCH, WAIT, COMMIT)
  - default TIMEOUT_CYC/GUARD_CYC constants
  - counter width localparam derived from TIMEOUT_CYC
- One sub-module, divseq_hilo: the HI/LO register pair with reset, MT write port and commit port. Commit has priority over MT on the same edge (cannot occur by construction; assert it).

## Test plan
- DIVU 100 / 7, divider model with 20-cycle latency → div_start pulses once; hi = 2, lo = 14 at edge GUARD-independent Ed+1; busy low after.
- DIV 0xFFFFFFF9 / 2, model returns signed results → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; div_sign = 1 throughout.
- rd_hi held high from issue through completion → hilo_stall high every busy cycle, low in the cycle hi = committed remainder. MTLO 0xAAAA while busy is not applied until IDLE, then lo = 0xAAAA.
- flush in the 5th WAIT cycle, hi/lo previously 0x11/0x22 → IDLE next edge, hi/lo stay 0x11/0x22; stale div_done high during the next divide's guard window is ignored.
- Divider model never asserts done → div_err = 1 after TIMEOUT_CYC WAIT cycles, state IDLE, hi/lo unchanged. rst_n low one edge clears div_err, hi, lo.
- With DIVSEQ_ZERO_BYPASS_EN: DIVU 0x1234 / 0 → no div_start, hi = 0x1234, lo = 0xFFFFFFFF two edges after issue. Without the macro, the same stimulus produces a div_start pulse.
